// File: rtl/puf_crp_verifier_pkg.sv
// Shared types and helpers for the arbiter-PUF challenge/response verifier.
package puf_crp_verifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRE    = 3'd1,
    ST_HIGH   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int C_LENGTH_DEF = 8;
  localparam int POP_W        = 4;
  localparam int POP_IN_W     = 64;

  // Ones count of a zero-extended word, saturating at the largest POP_W value.
  function automatic logic [POP_W-1:0] popcount_sat(input logic [POP_IN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_IN_W; i++) begin
      if (v[i]) n++;
    end
    if (n > (2**POP_W - 1)) return {POP_W{1'b1}};
    else return POP_W'(n);
  endfunction

endpackage

// File: rtl/puf_crp_verifier_resp_sync.sv
// Per-bit two-flop synchronizer bringing the asynchronous PUF response into the clock domain.
module puf_resp_sync #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/puf_crp_verifier.sv
// Arbiter-PUF verifier: launches a challenge N_VOTES times, majority-votes the response, grades it.
// Optional stability outputs are built when PUF_VERIFY_STABILITY_EN is defined.
module puf_crp_verifier
  import puf_crp_verifier_pkg::*;
#(
  parameter int C_LENGTH      = C_LENGTH_DEF,
  parameter int N_VOTES       = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int HD_THRESH     = 1
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                istart,
  input  logic [C_LENGTH-1:0] ichallenge,
  input  logic [C_LENGTH-1:0] iexpected,
  input  logic [C_LENGTH-1:0] iresponse,
  output logic [C_LENGTH-1:0] ochallenge,
  output logic                opulse,
  output logic                obusy,
  output logic                odone,
  output logic [C_LENGTH-1:0] ovoted,
  output logic [POP_W-1:0]    ohd,
  output logic                opass
`ifdef PUF_VERIFY_STABILITY_EN
  ,
  output logic [C_LENGTH-1:0] ounstable,
  output logic [POP_W-1:0]    ounstable_cnt
`endif
);

  localparam int OW = $clog2(N_VOTES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [OW-1:0]    VOTES_N     = OW'(N_VOTES);
  localparam logic [OW-1:0]    VOTES_LAST  = OW'(N_VOTES - 1);
  localparam logic [OW-1:0]    VOTES_HALF  = OW'(N_VOTES / 2);
  localparam logic [POP_W-1:0] HD_LIMIT    = POP_W'(HD_THRESH);

  state_e              state_q;
  logic [SW-1:0]       settle_q;
  logic [OW-1:0]       votes_q;
  logic [OW-1:0]       ones_q [C_LENGTH];
  logic [C_LENGTH-1:0] chal_q;
  logic [C_LENGTH-1:0] exp_q;
  logic [C_LENGTH-1:0] voted_q;
  logic [POP_W-1:0]    hd_q;
  logic                pulse_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [C_LENGTH-1:0] voted_d;
  logic [POP_W-1:0]    hd_d;
  logic [C_LENGTH-1:0] resp_sync;

  puf_resp_sync #(.W(C_LENGTH)) u_sync (
    .clk_i  (iclk),
    .rst_i  (irst),
    .async_i(iresponse),
    .sync_o (resp_sync)
  );

  always_comb begin
    voted_d = '0;
    for (int i = 0; i < C_LENGTH; i++) begin
      voted_d[i] = (ones_q[i] > VOTES_HALF);
    end
    hd_d = popcount_sat(POP_IN_W'(voted_d ^ exp_q));
  end

`ifdef PUF_VERIFY_STABILITY_EN
  logic [C_LENGTH-1:0] unstable_q;
  logic [POP_W-1:0]    unstable_cnt_q;
  logic [C_LENGTH-1:0] unstable_d;

  // A bit is unstable when its launches disagreed at least once.
  always_comb begin
    unstable_d = '0;
    for (int i = 0; i < C_LENGTH; i++) begin
      unstable_d[i] = (ones_q[i] != '0) && (ones_q[i] != VOTES_N);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      unstable_q     <= '0;
      unstable_cnt_q <= '0;
    end else if (state_q == ST_IDLE && istart) begin
      unstable_q     <= '0;
      unstable_cnt_q <= '0;
    end else if (state_q == ST_DECIDE) begin
      unstable_q     <= unstable_d;
      unstable_cnt_q <= popcount_sat(POP_IN_W'(unstable_d));
    end
  end

  assign ounstable     = unstable_q;
  assign ounstable_cnt = unstable_cnt_q;
`endif

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      votes_q  <= '0;
      chal_q   <= '0;
      exp_q    <= '0;
      voted_q  <= '0;
      hd_q     <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      for (int i = 0; i < C_LENGTH; i++) ones_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (istart) begin
            chal_q   <= ichallenge;
            exp_q    <= iexpected;
            votes_q  <= '0;
            settle_q <= '0;
            voted_q  <= '0;
            hd_q     <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_PRE;
            for (int i = 0; i < C_LENGTH; i++) ones_q[i] <= '0;
          end
        end
        ST_PRE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_q <= '0;
            pulse_q  <= 1'b1;
            state_q  <= ST_HIGH;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (settle_q == SETTLE_LAST) begin
            // Arbiters have settled by the last high cycle; bank this launch's bits.
            settle_q <= '0;
            pulse_q  <= 1'b0;
            votes_q  <= votes_q + 1'b1;
            for (int i = 0; i < C_LENGTH; i++) ones_q[i] <= ones_q[i] + OW'(resp_sync[i]);
            state_q  <= (votes_q == VOTES_LAST) ? ST_DECIDE : ST_PRE;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        ST_DECIDE: begin
          voted_q <= voted_d;
          hd_q    <= hd_d;
          pass_q  <= (hd_d <= HD_LIMIT);
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ochallenge = chal_q;
  assign opulse     = pulse_q;
  assign obusy      = busy_q;
  assign odone      = done_q;
  assign ovoted     = voted_q;
  assign ohd        = hd_q;
  assign opass      = pass_q;

endmodule

// File: tb/tb_puf_crp_verifier.sv
// Self-checking bench for puf_crp_verifier with a launch-indexed PUF response model.
module tb_puf_crp_verifier;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       istart = 1'b0;
  logic [7:0] ichallenge = 8'h00;
  logic [7:0] iexpected = 8'h00;
  logic [7:0] iresponse = 8'h00;
  logic [7:0] ochallenge;
  logic       opulse;
  logic       obusy;
  logic       odone;
  logic [7:0] ovoted;
  logic [3:0] ohd;
  logic       opass;
`ifdef PUF_VERIFY_STABILITY_EN
  logic [7:0] ounstable;
  logic [3:0] ounstable_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] resp_tbl [5];
  int         launch_n = 0;
  logic       pulse_prev = 1'b0;

  puf_crp_verifier dut (
    .iclk      (iclk),
    .irst      (irst),
    .istart    (istart),
    .ichallenge(ichallenge),
    .iexpected (iexpected),
    .iresponse (iresponse),
    .ochallenge(ochallenge),
    .opulse    (opulse),
    .obusy     (obusy),
    .odone     (odone),
    .ovoted    (ovoted),
    .ohd       (ohd),
    .opass     (opass)
`ifdef PUF_VERIFY_STABILITY_EN
    ,
    .ounstable    (ounstable),
    .ounstable_cnt(ounstable_cnt)
`endif
  );

  always #5 iclk = ~iclk;

  // PUF array model: each rising launch edge presents the next table entry.
  always @(negedge iclk) begin
    if (obusy !== 1'b1) begin
      launch_n = 0;
    end else if (opulse === 1'b1 && pulse_prev !== 1'b1) begin
      iresponse = resp_tbl[launch_n % 5];
      launch_n = launch_n + 1;
    end
    pulse_prev = opulse;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tbl(input logic [7:0] r0, r1, r2, r3, r4);
    resp_tbl[0] = r0; resp_tbl[1] = r1; resp_tbl[2] = r2;
    resp_tbl[3] = r3; resp_tbl[4] = r4;
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge of the cycle after odone.
  task automatic do_run(input string tag, input logic [7:0] chal, input logic [7:0] expv,
                        input bit glitch);
    logic [7:0] m_voted, m_unst;
    int ones, m_hd, done_cyc;
    bit chal_ok;
    m_voted = 8'h00; m_unst = 8'h00; m_hd = 0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int l = 0; l < 5; l++) ones += int'(resp_tbl[l][b]);
      m_voted[b] = (ones >= 3);
      m_unst[b]  = (ones != 0) && (ones != 5);
    end
    for (int b = 0; b < 8; b++) if (m_voted[b] != expv[b]) m_hd++;

    istart = 1'b1; ichallenge = chal; iexpected = expv;
    @(negedge iclk);
    istart = 1'b0; ichallenge = 8'($urandom); iexpected = 8'($urandom);
    check({tag, " c1_busy"}, 32'(obusy), 32'd1);
    check({tag, " c1_voted_clr"}, 32'(ovoted), 32'd0);
    check({tag, " c1_hd_pass_clr"}, 32'({ohd, opass}), 32'd0);
    check({tag, " c1_chal"}, 32'(ochallenge), 32'(chal));
    done_cyc = -1;
    chal_ok = 1'b1;
    for (int c = 2; c <= 60 && done_cyc < 0; c++) begin
      @(negedge iclk);
      istart = glitch && (c == 5 || c == 20);
      if (ochallenge !== chal) chal_ok = 1'b0;
      if (odone === 1'b1) done_cyc = c;
    end
    istart = 1'b0;
    check({tag, " done_cycle"}, 32'(done_cyc), 32'd42);
    check({tag, " voted"}, 32'(ovoted), 32'(m_voted));
    check({tag, " hd"}, 32'(ohd), 32'(m_hd));
    check({tag, " pass"}, 32'(opass), 32'(m_hd <= 1));
    check({tag, " launches"}, 32'(launch_n), 32'd5);
    check({tag, " chal_const"}, 32'(chal_ok), 32'd1);
`ifdef PUF_VERIFY_STABILITY_EN
    check({tag, " unstable"}, 32'(ounstable), 32'(m_unst));
    check({tag, " unstable_cnt"}, 32'(ounstable_cnt), 32'($countones(m_unst)));
`else
    if (m_unst === 8'hxx) $display("model unstable mask undefined");
`endif
    @(negedge iclk);
    check({tag, " after_busy"}, 32'(obusy), 32'd0);
    check({tag, " after_done"}, 32'(odone), 32'd0);
    check({tag, " hold_voted"}, 32'(ovoted), 32'(m_voted));
  endtask

  initial begin
    logic [7:0] w;
    set_tbl(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge iclk);
    check("rst_outputs", 32'({ochallenge, opulse, obusy, odone, ovoted, ohd, opass}), 32'd0);
    irst = 1'b0;
    @(negedge iclk);

    set_tbl(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    do_run("const_a5", 8'h3C, 8'hA5, 1'b0);
    set_tbl(8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'hA5);
    do_run("alt_a5_5a", 8'h3C, 8'hA5, 1'b0);
    set_tbl(8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'hA7);
    do_run("hd1", 8'h11, 8'hA5, 1'b0);
    set_tbl(8'hA6, 8'hA6, 8'hA6, 8'hA6, 8'hA6);
    do_run("hd2", 8'h22, 8'hA5, 1'b0);
    repeat (2) @(negedge iclk);
    set_tbl(8'hC3, 8'hC3, 8'h00, 8'hC3, 8'hFF);
    do_run("start_glitch", 8'h77, 8'hC3, 1'b1);

    // Abort a run mid-way with reset, then confirm a clean restart.
    set_tbl(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    istart = 1'b1; ichallenge = 8'h9E; iexpected = 8'hFF;
    @(negedge iclk);
    istart = 1'b0;
    repeat (16) @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    check("midrst_outputs", 32'({ochallenge, opulse, obusy, odone, ovoted, ohd, opass}), 32'd0);
    irst = 1'b0;
    set_tbl(8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'hF0);
    do_run("post_rst", 8'h9E, 8'h0F, 1'b0);

    // Reset and start together: reset must win.
    irst = 1'b1; istart = 1'b1; ichallenge = 8'hFF;
    @(negedge iclk);
    check("rst_vs_start_busy", 32'(obusy), 32'd0);
    check("rst_vs_start_chal", 32'(ochallenge), 32'd0);
    irst = 1'b0; istart = 1'b0;
    @(negedge iclk);

    for (int k = 0; k < 4; k++) begin
      w = 8'($urandom);
      for (int l = 0; l < 5; l++) resp_tbl[l] = (k < 2) ? (w ^ 8'($urandom_range(0, 3))) : 8'($urandom);
      do_run("random", 8'($urandom), (k == 0) ? w : 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
